// File: rtl/countdown_timer_pkg.sv
// ============================================================================
// Module   : countdown_timer_pkg
// Brief    : Shared clock/timer definitions: FSM state encoding, seconds
//            range and time-field width. Also used by the up-counter blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package countdown_timer_pkg;

  // Timer FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } timer_state_t;

  // Largest seconds value and width of every mm / ss field
  localparam int SEC_MAX = 59;
  localparam int FIELD_W = 6;

endpackage : countdown_timer_pkg

`default_nettype wire

// File: rtl/countdown_digit.sv
// ============================================================================
// Module   : countdown_digit
// Brief    : One mod-N down-counter digit with synchronous load, decrement
//            enable, zero flag and borrow-out (asserted when a decrement
//            wraps the digit from 0 to N-1). Load has priority over dec_en.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_digit #(
  parameter int N = 60,
  parameter int W = 6
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec_en,
  output logic [W-1:0] value,
  output logic         zero,
  output logic         borrow
);

  localparam logic [W-1:0] C_TOP = W'(N - 1);

  logic [W-1:0] r_value;

  // Digit register: load wins, otherwise decrement with wrap to N-1
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_value <= '0;
    end else if (load) begin
      r_value <= load_value;
    end else if (dec_en) begin
      r_value <= (r_value == '0) ? C_TOP : (r_value - 1'b1);
    end
  end

  assign value  = r_value;
  assign zero   = (r_value == '0);
  assign borrow = dec_en & zero & ~load;

endmodule : countdown_digit

`default_nettype wire

// File: rtl/countdown_timer.sv
// ============================================================================
// Module   : countdown_timer
// Brief    : mm:ss countdown timer. Preset edited with increment buttons in
//            IDLE, counts down on the 1 Hz enable, raises done/alarm at 00:00.
//            Optional macro COUNTDOWN_AUTORELOAD_EN: reload preset on expiry,
//            stay in RUN, pulse done for one cycle, alarm runs independently.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_timer #(
  parameter int MAX_MIN     = 59,
  parameter int ALARM_TICKS = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_sec,
  input  logic       start_stop,
  input  logic       clear,
  output logic [5:0] count_min,
  output logic [5:0] count_sec,
  output logic       borrow_sec,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  import countdown_timer_pkg::*;

  localparam logic [FIELD_W-1:0] C_SEC_MAX   = FIELD_W'(SEC_MAX);
  localparam logic [FIELD_W-1:0] C_MAX_MIN   = FIELD_W'(MAX_MIN);
  localparam logic [7:0]         C_ALARM_TKS = 8'(ALARM_TICKS);

  timer_state_t       r_state;
  logic [FIELD_W-1:0] r_pre_min;
  logic [FIELD_W-1:0] r_pre_sec;
  logic [7:0]         r_alarm_cnt;
  logic               r_borrow_sec;
  logic               r_running;
  logic               r_done;
  logic               r_alarm;

  logic [FIELD_W-1:0] w_pre_min_nxt;
  logic [FIELD_W-1:0] w_pre_sec_nxt;
  logic [FIELD_W-1:0] w_cnt_min;
  logic [FIELD_W-1:0] w_cnt_sec;
  logic               w_min_zero;
  logic               w_sec_zero;
  logic               w_min_borrow;
  logic               w_sec_borrow;
  logic               w_preset_zero;
  logic               w_run_tick;
  logic               w_last;
  logic               w_load;
  logic               w_dec_sec;
  logic               w_dec_min;

  // Next preset, counter load/decrement controls and expiry detection
  always_comb begin
    w_pre_min_nxt = r_pre_min;
    w_pre_sec_nxt = r_pre_sec;
    if ((r_state == ST_IDLE) && set_mode && !clear && !start_stop) begin
      if (inc_sec) w_pre_sec_nxt = (r_pre_sec == C_SEC_MAX) ? '0 : (r_pre_sec + 1'b1);
      if (inc_min) w_pre_min_nxt = (r_pre_min == C_MAX_MIN) ? '0 : (r_pre_min + 1'b1);
    end
    w_preset_zero = (r_pre_min == '0) && (r_pre_sec == '0);
    w_run_tick    = (r_state == ST_RUN) && tick_1hz && !clear && !start_stop;
    // This tick takes the count from 00:01 to 00:00
    w_last        = w_run_tick && w_min_zero && (w_cnt_sec == FIELD_W'(1));
    // Count follows the preset in IDLE and reloads it on every exit to IDLE
    w_load        = clear || (r_state == ST_IDLE) || ((r_state == ST_DONE) && start_stop);
`ifdef COUNTDOWN_AUTORELOAD_EN
    w_load        = w_load || w_last;
`endif
    w_dec_sec     = w_run_tick;
    w_dec_min     = w_run_tick && w_sec_zero;
  end

  countdown_digit #(
    .N (SEC_MAX + 1),
    .W (FIELD_W)
  ) u_sec (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (w_load),
    .load_value (w_pre_sec_nxt),
    .dec_en     (w_dec_sec),
    .value      (w_cnt_sec),
    .zero       (w_sec_zero),
    .borrow     (w_sec_borrow)
  );

  countdown_digit #(
    .N (MAX_MIN + 1),
    .W (FIELD_W)
  ) u_min (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (w_load),
    .load_value (w_pre_min_nxt),
    .dec_en     (w_dec_min),
    .value      (w_cnt_min),
    .zero       (w_min_zero),
    .borrow     (w_min_borrow)
  );

  // Timer FSM with preset, alarm counter and registered status outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_pre_min    <= '0;
      r_pre_sec    <= '0;
      r_alarm_cnt  <= '0;
      r_borrow_sec <= 1'b0;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_alarm      <= 1'b0;
    end else begin
      r_pre_min    <= w_pre_min_nxt;
      r_pre_sec    <= w_pre_sec_nxt;
      // A seconds wrap is only a genuine borrow if minutes did not underflow
      r_borrow_sec <= w_sec_borrow & ~w_min_borrow;
`ifdef COUNTDOWN_AUTORELOAD_EN
      r_done       <= 1'b0;
`endif
      // Alarm countdown runs on ticks; expiry below restarts it
      if (tick_1hz && (r_alarm_cnt != '0)) begin
        r_alarm_cnt <= r_alarm_cnt - 1'b1;
        if (r_alarm_cnt == 8'd1) r_alarm <= 1'b0;
      end

      if (clear) begin
        r_state     <= ST_IDLE;
        r_running   <= 1'b0;
        r_done      <= 1'b0;
        r_alarm     <= 1'b0;
        r_alarm_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start_stop && !w_preset_zero) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (start_stop) begin
              r_state   <= ST_PAUSE;
              r_running <= 1'b0;
            end else if (w_last) begin
              r_done      <= 1'b1;
              r_alarm     <= 1'b1;
              r_alarm_cnt <= C_ALARM_TKS;
`ifndef COUNTDOWN_AUTORELOAD_EN
              r_state     <= ST_DONE;
              r_running   <= 1'b0;
`endif
            end
          end
          ST_PAUSE: begin
            if (start_stop) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end
          ST_DONE: begin
            if (start_stop) begin
              r_state     <= ST_IDLE;
              r_done      <= 1'b0;
              r_alarm     <= 1'b0;
              r_alarm_cnt <= '0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign count_min  = w_cnt_min;
  assign count_sec  = w_cnt_sec;
  assign borrow_sec = r_borrow_sec;
  assign running    = r_running;
  assign done       = r_done;
  assign alarm      = r_alarm;

endmodule : countdown_timer

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// ============================================================================
// Module   : tb_countdown_timer
// Brief    : Directed, table-driven bench for countdown_timer (default build,
//            MAX_MIN=59, ALARM_TICKS=10) plus multi-cycle corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_countdown_timer;

  logic       clock;
  logic       reset_n;
  logic       tick_1hz;
  logic       set_mode;
  logic       inc_min;
  logic       inc_sec;
  logic       start_stop;
  logic       clear;
  logic [5:0] count_min;
  logic [5:0] count_sec;
  logic       borrow_sec;
  logic       running;
  logic       done;
  logic       alarm;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic sm, im, is, ss, cl, tk;
    int   emin, esec;
    logic eb, er, ed, ea;
  } vec_t;

  vec_t vecs[$];

  countdown_timer #(
    .MAX_MIN     (59),
    .ALARM_TICKS (10)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .tick_1hz   (tick_1hz),
    .set_mode   (set_mode),
    .inc_min    (inc_min),
    .inc_sec    (inc_sec),
    .start_stop (start_stop),
    .clear      (clear),
    .count_min  (count_min),
    .count_sec  (count_sec),
    .borrow_sec (borrow_sec),
    .running    (running),
    .done       (done),
    .alarm      (alarm)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int emin, input int esec,
                         input logic eb, input logic er, input logic ed, input logic ea);
    chk({name, ".min"},     int'(count_min),  emin);
    chk({name, ".sec"},     int'(count_sec),  esec);
    chk({name, ".borrow"},  int'(borrow_sec), int'(eb));
    chk({name, ".running"}, int'(running),    int'(er));
    chk({name, ".done"},    int'(done),       int'(ed));
    chk({name, ".alarm"},   int'(alarm),      int'(ea));
  endtask

  // One clock cycle with the given inputs, outputs settle 1 time unit after the edge
  task automatic cyc(input logic sm, input logic im, input logic is,
                     input logic ss, input logic cl, input logic tk);
    @(negedge clock);
    set_mode = sm; inc_min = im; inc_sec = is; start_stop = ss; clear = cl; tick_1hz = tk;
    @(posedge clock);
    #1;
    set_mode = 1'b0; inc_min = 1'b0; inc_sec = 1'b0; start_stop = 1'b0; clear = 1'b0; tick_1hz = 1'b0;
  endtask

  task automatic add(input logic sm, input logic im, input logic is, input logic ss,
                     input logic cl, input logic tk, input int emin, input int esec,
                     input logic eb, input logic er, input logic ed, input logic ea);
    vec_t v;
    v.sm = sm; v.im = im; v.is = is; v.ss = ss; v.cl = cl; v.tk = tk;
    v.emin = emin; v.esec = esec; v.eb = eb; v.er = er; v.ed = ed; v.ea = ea;
    vecs.push_back(v);
  endtask

  initial begin
    reset_n = 1'b0; tick_1hz = 1'b0; set_mode = 1'b0; inc_min = 1'b0;
    inc_sec = 1'b0; start_stop = 1'b0; clear = 1'b0;

    // Vector table: set preset 00:03 and run it down to expiry
    //   sm im is ss cl tk  min sec  b  r  d  a
    add(1, 0, 1, 0, 0, 0,  0, 1,  0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0,  0, 2,  0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 1,  0, 3,  0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,  0, 3,  0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0,  0, 3,  0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,  0, 2,  0, 1, 0, 0);
    add(1, 1, 1, 0, 0, 0,  0, 2,  0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,  0, 1,  0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,  0, 0,  0, 0, 1, 1);
    add(1, 1, 0, 0, 0, 0,  0, 0,  0, 0, 1, 1);

    repeat (3) @(posedge clock);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].sm, vecs[i].im, vecs[i].is, vecs[i].ss, vecs[i].cl, vecs[i].tk);
      chk_all($sformatf("vec%0d", i), vecs[i].emin, vecs[i].esec,
              vecs[i].eb, vecs[i].er, vecs[i].ed, vecs[i].ea);
    end

    // Alarm holds for 9 ticks and drops on the 10th
    for (int i = 1; i <= 9; i++) begin
      cyc(0, 0, 0, 0, 0, 1);
      chk($sformatf("alarm_hold%0d", i), int'(alarm), 1);
    end
    cyc(0, 0, 0, 0, 0, 1);
    chk_all("alarm_drop", 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk_all("ack_idle", 0, 3, 0, 0, 0, 0);

    // Borrow: build preset 01:00 (seconds 3 -> wrap to 0 takes 57 pulses)
    for (int i = 0; i < 57; i++) cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk_all("preset_0100", 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk_all("borrow_tick", 0, 59, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk_all("borrow_gone", 0, 59, 0, 1, 0, 0);
    for (int i = 0; i < 58; i++) cyc(0, 0, 0, 0, 0, 1);
    chk_all("borrow_0001", 0, 1, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk_all("borrow_done", 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk_all("borrow_ack", 1, 0, 0, 0, 0, 0);

    // Pause collision at 00:10
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 50; i++) cyc(0, 0, 0, 0, 0, 1);
    chk_all("run_0010", 0, 10, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 1);
    chk_all("pause_collide", 0, 10, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1);
    chk_all("pause_frozen", 0, 10, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk_all("resume", 0, 10, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk_all("resume_tick", 0, 9, 0, 1, 0, 0);

    // Clear beats start_stop at 00:05
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1);
    chk_all("run_0005", 0, 5, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    chk_all("clear_prio", 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk_all("clear_idle", 1, 0, 0, 0, 0, 0);

    // Preset wrap: minutes 1 -> 0 (59 pulses), then a full MAX_MIN+1 lap
    for (int i = 0; i < 59; i++) cyc(1, 1, 0, 0, 0, 0);
    chk_all("min_to0", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 59; i++) cyc(1, 1, 0, 0, 0, 0);
    chk_all("min_59", 59, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk_all("min_wrap", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 59; i++) cyc(1, 0, 1, 0, 0, 0);
    chk_all("sec_59", 0, 59, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    chk_all("sec_wrap", 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk_all("zero_start", 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk_all("zero_tick", 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    chk_all("both_inc", 1, 1, 0, 0, 0, 0);

    // Reset mid-alarm: preset 00:01, expire, then asynchronous reset
    for (int i = 0; i < 59; i++) cyc(1, 1, 0, 0, 0, 0);
    chk_all("preset_0001", 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk_all("expire_0001", 0, 0, 0, 0, 1, 1);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    cyc(0, 0, 0, 1, 0, 1);
    chk_all("post_reset", 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_countdown_timer

`default_nettype wire

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Down-counting mm:ss timer; the counterpart of the up-counting minute/second chain in the clock design.
- The user sets a preset with the same increment-button style as clock setting, then starts the countdown.
- Counts down on the shared 1 Hz enable and borrows seconds→minutes.
- Flags expiry and drives the buzzer and the display mux.

Parameters:
- MAX_MIN, 59, largest settable/displayed minute value (6-bit field; must be ≤ 63).
- ALARM_TICKS, 10, number of 1 Hz ticks the alarm output stays high after expiry (1..255).

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset_n  input  1  asynchronous active-low reset.
- tick_1hz  input  1  one-cycle enable, once per second.
- set_mode  input  1  level; while high and timer in IDLE, inc buttons edit the preset.
- inc_min  input  1  one-cycle pulse; preset minutes +1, wraps MAX_MIN→0.
- inc_sec  input  1  one-cycle pulse; preset seconds +1, wraps 59→0.
- start_stop  input  1  one-cycle pulse; start / pause / resume / acknowledge.
- clear  input  1  one-cycle pulse; abort to IDLE and reload preset.
- count_min  output  6  current minutes (preset while in IDLE).
- count_sec  output  6  current seconds (preset while in IDLE).
- borrow_sec  output  1  one-cycle pulse when seconds wrap 00→59.
- running  output  1  high in RUN.
- done  output  1  high in DONE.
- alarm  output  1  buzzer drive.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; preset=00:00; count=00:00; all 1-bit outputs 0; alarm counter 0.
- States: IDLE, RUN, PAUSE, DONE. Registered outputs, updated on the same edge as the state change; no extra latency.
- Input priority each cycle: clear > start_stop > inc_* > tick_1hz.

IDLE:
- count mirrors preset.
- With set_mode=1: inc_min / inc_sec update the preset next edge. Both pulsed in the same cycle: both fields increment.
- With set_mode=0: inc_* are ignored.
- start_stop with preset≠00:00 → RUN; count is loaded from preset (already equal). start_stop with preset=00:00 is ignored.

RUN:
- On tick_1hz:
  - sec>0: sec−1.
  - sec=0 and min>0: sec=59, min−1, borrow_sec=1 for that cycle.
- On the edge where count becomes 00:00: state→DONE, done=1, alarm=1, alarm counter=ALARM_TICKS.
- start_stop → PAUSE. A tick in the same cycle is discarded (count unchanged).
- set_mode and inc_* are ignored in RUN, PAUSE and DONE.

PAUSE:
- Count frozen; ticks ignored.
- start_stop → RUN; the next tick decrements.

DONE:
- count stays 00:00.
- Each tick decrements the alarm counter; alarm drops on the edge the counter reaches 0.
- done stays high until start_stop or clear → IDLE; count reloads preset, alarm=0.

clear:
- From any state → IDLE, count=preset, alarm=0, borrow_sec=0. Preset is retained.

Arithmetic:
- 6-bit unsigned; no value ever exceeds 59 (sec) or MAX_MIN (min).
- Minutes never underflow: RUN always exits to DONE at 00:00.
- Reset asserted mid-RUN or mid-DONE clears everything immediately, including alarm.

Optional Feature:
- COUNTDOWN_AUTORELOAD_EN defined:
  - On reaching 00:00 the timer reloads preset on the same edge and stays in RUN.
  - done pulses for one cycle; alarm still runs ALARM_TICKS ticks, independent of counting.
  - A new expiry during an active alarm restarts the alarm counter.
- Not defined: DONE behaviour exactly as above.

Decomposition:
- Shared clock package:
  - state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3);
  - constants SEC_MAX=59 and field width 6.
  - The up-counter blocks reuse SEC_MAX and the width.
- Sub-module countdown_digit: one mod-N down-counter with load value, decrement enable, zero flag and borrow out. Instantiated twice (seconds N=60, minutes N=MAX_MIN+1). The top holds the FSM, preset registers and alarm counter.

Test Plan:
- Reset mid-alarm: expiry reached, alarm=1; pull reset_n low between clock edges → all outputs 0 immediately, count 00:00, state IDLE.
- Set and run short: set_mode=1, inc_sec×3 → preset 00:03; start_stop, 3 ticks → count 00:02, 00:01, 00:00; done=1 and alarm=1 on the third tick edge; alarm low exactly after 10 further ticks; start_stop → IDLE, count 00:03.
- Borrow: preset 01:00, start, 1 tick → count 00:59, borrow_sec high exactly one cycle; 59 more ticks → done.
- Pause collision: RUN at 00:10, start_stop and tick_1hz in the same cycle → PAUSE, count stays 00:10; 5 ticks → unchanged; start_stop, 1 tick → 00:09.
- Preset wrap and zero start:
  - 59 inc_sec pulses from 00 → 59; one more → 00.
  - MAX_MIN+1 inc_min pulses → min 00.
  - start_stop at preset 00:00 → stays IDLE, running=0.
- Clear priority: RUN at 00:05, clear and start_stop in the same cycle → IDLE, count=preset, no PAUSE entered.
